// File: rtl/coreaxi4dmacontroller_ctrl_if_axi4lite_slv.sv
`default_nettype none
// ============================================================================
// coreaxi4dmacontroller_ctrl_if_axi4lite_slv
// AXI4-Lite slave that issues one access at a time on the internal register bus.
// Optional stall abort: COREAXI4DMACONTROLLER_CTRL_IF_TIMEOUT_EN
// Revision: 1.0
// ============================================================================
module coreaxi4dmacontroller_ctrl_if_axi4lite_slv #(
    parameter int ADDR_WIDTH = 32,
    parameter int RD_TIMEOUT = 256
) (
    input  logic                  CLOCK,
    input  logic                  RESETN,
    input  logic                  CTRL_AWVALID,
    output logic                  CTRL_AWREADY,
    input  logic [ADDR_WIDTH-1:0] CTRL_AWADDR,
    input  logic                  CTRL_WVALID,
    output logic                  CTRL_WREADY,
    input  logic [31:0]           CTRL_WDATA,
    input  logic [3:0]            CTRL_WSTRB,
    output logic                  CTRL_BVALID,
    input  logic                  CTRL_BREADY,
    output logic [1:0]            CTRL_BRESP,
    input  logic                  CTRL_ARVALID,
    output logic                  CTRL_ARREADY,
    input  logic [ADDR_WIDTH-1:0] CTRL_ARADDR,
    output logic                  CTRL_RVALID,
    input  logic                  CTRL_RREADY,
    output logic [31:0]           CTRL_RDATA,
    output logic [1:0]            CTRL_RRESP,
    output logic                  REG_WR,
    output logic                  REG_RD,
    output logic [10:0]           REG_ADDR,
    output logic [31:0]           REG_WDATA,
    output logic [3:0]            REG_BE,
    input  logic                  REG_READY,
    input  logic [31:0]           REG_RDATA,
    input  logic                  REG_RDATA_VALID
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_ISSUE = 3'd1,
        WR_RESP  = 3'd2,
        RD_ISSUE = 3'd3,
        RD_WAIT  = 3'd4,
        RD_RESP  = 3'd5
    } state_t;

    state_t      state, state_nxt;
    logic        prio_wr;
    logic [8:0]  addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [3:0]  be_q;
    logic        slverr_q;
    logic        write_req, rd_req, grant_wr, grant_rd;
    logic        timeout;
    logic        unused_addr_bits;

    assign write_req = CTRL_AWVALID & CTRL_WVALID;
    assign rd_req    = CTRL_ARVALID;
    // Contention goes to whichever side did not win last; uncontested requests always win.
    assign grant_wr  = write_req & (~rd_req | prio_wr);
    assign grant_rd  = rd_req & (~write_req | ~prio_wr);

    assign unused_addr_bits = ^{CTRL_AWADDR[ADDR_WIDTH-1:11], CTRL_AWADDR[1:0],
                                CTRL_ARADDR[ADDR_WIDTH-1:11], CTRL_ARADDR[1:0]};

`ifdef COREAXI4DMACONTROLLER_CTRL_IF_TIMEOUT_EN
    localparam int CNT_W = ($clog2(RD_TIMEOUT) < 8) ? 8 : $clog2(RD_TIMEOUT);
    logic [CNT_W-1:0] cnt;
    logic             cnt_state, cnt_state_nxt;

    assign cnt_state     = (state == WR_ISSUE) || (state == RD_ISSUE) || (state == RD_WAIT);
    assign cnt_state_nxt = (state_nxt == WR_ISSUE) || (state_nxt == RD_ISSUE) || (state_nxt == RD_WAIT);
    assign timeout       = cnt_state && (cnt == CNT_W'(RD_TIMEOUT - 1));

    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            cnt <= '0;
        end else if (cnt_state_nxt && (state_nxt != state)) begin
            cnt <= '0;
        end else if (cnt_state) begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Progress is tested before timeout so a last-cycle ready still completes normally.
    always_comb begin
        state_nxt    = state;
        CTRL_AWREADY = 1'b0;
        CTRL_WREADY  = 1'b0;
        CTRL_ARREADY = 1'b0;
        unique case (state)
            IDLE: begin
                CTRL_AWREADY = grant_wr;
                CTRL_WREADY  = grant_wr;
                CTRL_ARREADY = grant_rd;
                if (grant_wr)      state_nxt = WR_ISSUE;
                else if (grant_rd) state_nxt = RD_ISSUE;
            end
            WR_ISSUE: if (REG_READY || timeout) state_nxt = WR_RESP;
            WR_RESP:  if (CTRL_BREADY) state_nxt = IDLE;
            RD_ISSUE: begin
                if (REG_READY && REG_RDATA_VALID) state_nxt = RD_RESP;
                else if (REG_READY)               state_nxt = RD_WAIT;
                else if (timeout)                 state_nxt = RD_RESP;
            end
            RD_WAIT:  if (REG_RDATA_VALID || timeout) state_nxt = RD_RESP;
            RD_RESP:  if (CTRL_RREADY) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            prio_wr  <= 1'b1;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            rdata_q  <= '0;
            slverr_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_wr) begin
                        addr_q   <= CTRL_AWADDR[10:2];
                        wdata_q  <= CTRL_WDATA;
                        be_q     <= CTRL_WSTRB;
                        prio_wr  <= 1'b0;
                        slverr_q <= 1'b0;
                    end else if (grant_rd) begin
                        addr_q   <= CTRL_ARADDR[10:2];
                        be_q     <= 4'hF;
                        prio_wr  <= 1'b1;
                        slverr_q <= 1'b0;
                    end
                end
                WR_ISSUE: begin
                    if (!REG_READY && timeout) slverr_q <= 1'b1;
                end
                RD_ISSUE: begin
                    if (REG_READY && REG_RDATA_VALID) begin
                        rdata_q <= REG_RDATA;
                    end else if (!REG_READY && timeout) begin
                        rdata_q  <= '0;
                        slverr_q <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (REG_RDATA_VALID) begin
                        rdata_q <= REG_RDATA;
                    end else if (timeout) begin
                        rdata_q  <= '0;
                        slverr_q <= 1'b1;
                    end
                end
                RD_RESP: begin
                    if (CTRL_RREADY) rdata_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign REG_WR      = (state == WR_ISSUE);
    assign REG_RD      = (state == RD_ISSUE);
    assign REG_ADDR    = {addr_q, 2'b00};
    assign REG_WDATA   = wdata_q;
    assign REG_BE      = be_q;
    assign CTRL_BVALID = (state == WR_RESP);
    assign CTRL_BRESP  = (CTRL_BVALID && slverr_q) ? 2'b10 : 2'b00;
    assign CTRL_RVALID = (state == RD_RESP);
    assign CTRL_RRESP  = (CTRL_RVALID && slverr_q) ? 2'b10 : 2'b00;
    assign CTRL_RDATA  = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_coreaxi4dmacontroller_ctrl_if_axi4lite_slv.sv
`default_nettype none
// ============================================================================
// tb_coreaxi4dmacontroller_ctrl_if_axi4lite_slv
// Directed table vectors plus hand sequences for arbitration, stalls and reset.
// Revision: 1.0
// ============================================================================
module tb_coreaxi4dmacontroller_ctrl_if_axi4lite_slv;

    logic        CLOCK = 1'b0;
    logic        RESETN;
    logic        CTRL_AWVALID, CTRL_WVALID, CTRL_BREADY, CTRL_ARVALID, CTRL_RREADY;
    logic        CTRL_AWREADY, CTRL_WREADY, CTRL_BVALID, CTRL_ARREADY, CTRL_RVALID;
    logic [31:0] CTRL_AWADDR, CTRL_ARADDR, CTRL_WDATA, CTRL_RDATA;
    logic [3:0]  CTRL_WSTRB;
    logic [1:0]  CTRL_BRESP, CTRL_RRESP;
    logic        REG_WR, REG_RD, REG_READY, REG_RDATA_VALID;
    logic [10:0] REG_ADDR;
    logic [31:0] REG_WDATA, REG_RDATA;
    logic [3:0]  REG_BE;

    int checks = 0;
    int errors = 0;

    coreaxi4dmacontroller_ctrl_if_axi4lite_slv #(
        .ADDR_WIDTH(32),
        .RD_TIMEOUT(16)
    ) dut (
        .CLOCK(CLOCK), .RESETN(RESETN),
        .CTRL_AWVALID(CTRL_AWVALID), .CTRL_AWREADY(CTRL_AWREADY), .CTRL_AWADDR(CTRL_AWADDR),
        .CTRL_WVALID(CTRL_WVALID), .CTRL_WREADY(CTRL_WREADY), .CTRL_WDATA(CTRL_WDATA),
        .CTRL_WSTRB(CTRL_WSTRB), .CTRL_BVALID(CTRL_BVALID), .CTRL_BREADY(CTRL_BREADY),
        .CTRL_BRESP(CTRL_BRESP), .CTRL_ARVALID(CTRL_ARVALID), .CTRL_ARREADY(CTRL_ARREADY),
        .CTRL_ARADDR(CTRL_ARADDR), .CTRL_RVALID(CTRL_RVALID), .CTRL_RREADY(CTRL_RREADY),
        .CTRL_RDATA(CTRL_RDATA), .CTRL_RRESP(CTRL_RRESP),
        .REG_WR(REG_WR), .REG_RD(REG_RD), .REG_ADDR(REG_ADDR), .REG_WDATA(REG_WDATA),
        .REG_BE(REG_BE), .REG_READY(REG_READY), .REG_RDATA(REG_RDATA),
        .REG_RDATA_VALID(REG_RDATA_VALID)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Mutual-exclusion invariants, checked on every falling edge.
    always @(negedge CLOCK) begin
        if (REG_WR && REG_RD) begin
            errors++;
            $display("FAIL excl_strobes: got REG_WR=1 REG_RD=1 expected not both");
        end
        if (CTRL_BVALID && CTRL_RVALID) begin
            errors++;
            $display("FAIL excl_resp: got BVALID=1 RVALID=1 expected not both");
        end
    end

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [10:0] exp_addr;
        logic [3:0]  exp_be;
    } vec_t;

    vec_t vecs[6];

    task automatic idle_inputs();
        CTRL_AWVALID = 0; CTRL_WVALID = 0; CTRL_ARVALID = 0;
        CTRL_BREADY = 0; CTRL_RREADY = 0;
        REG_READY = 0; REG_RDATA_VALID = 0;
    endtask

    task automatic do_write(input vec_t v);
        @(negedge CLOCK);
        CTRL_AWVALID = 1; CTRL_WVALID = 1; CTRL_AWADDR = v.addr;
        CTRL_WDATA = v.data; CTRL_WSTRB = v.strb; REG_READY = 1;
        #1 chk("wr_awready", {CTRL_AWREADY, CTRL_WREADY}, 2'b11);
        @(negedge CLOCK);
        CTRL_AWVALID = 0; CTRL_WVALID = 0;
        #1 chk("wr_issue", {REG_WR, CTRL_BVALID}, 2'b10);
        chk("wr_addr", REG_ADDR, v.exp_addr);
        chk("wr_data", REG_WDATA, v.data);
        chk("wr_be", REG_BE, v.exp_be);
        @(negedge CLOCK);
        CTRL_BREADY = 1;
        #1 chk("wr_bvalid", {CTRL_BVALID, CTRL_BRESP, REG_WR}, 4'b1000);
        @(negedge CLOCK);
        CTRL_BREADY = 0;
        #1 chk("wr_bdone", CTRL_BVALID, 1'b0);
    endtask

    task automatic do_read(input vec_t v);
        @(negedge CLOCK);
        CTRL_ARVALID = 1; CTRL_ARADDR = v.addr;
        REG_READY = 1; REG_RDATA_VALID = 1; REG_RDATA = v.data;
        #1 chk("rd_arready", CTRL_ARREADY, 1'b1);
        @(negedge CLOCK);
        CTRL_ARVALID = 0;
        #1 chk("rd_issue", {REG_RD, CTRL_RVALID}, 2'b10);
        chk("rd_addr", REG_ADDR, v.exp_addr);
        chk("rd_be", REG_BE, 4'hF);
        @(negedge CLOCK);
        CTRL_RREADY = 1; REG_RDATA = 32'hDEAD_BEEF;
        #1 chk("rd_rvalid", {CTRL_RVALID, CTRL_RRESP, REG_RD}, 4'b1000);
        chk("rd_rdata", CTRL_RDATA, v.data);
        @(negedge CLOCK);
        CTRL_RREADY = 0; REG_RDATA_VALID = 0;
        #1 chk("rd_rdone", {CTRL_RVALID, CTRL_RDATA}, 33'h0);
    endtask

    task automatic apply_reset();
        @(negedge CLOCK);
        RESETN = 0;
        idle_inputs();
        repeat (2) @(negedge CLOCK);
        RESETN = 1;
    endtask

    initial begin
        int n;
        logic [31:0] held;
        logic stable;
        int beats;

        vecs[0] = '{1'b1, 32'h0000_0464, 32'hA5A5_1234, 4'h3, 11'h464, 4'h3};
        vecs[1] = '{1'b0, 32'h0000_0063, 32'h1122_3344, 4'h0, 11'h060, 4'hF};
        vecs[2] = '{1'b1, 32'hFFFF_F7FF, 32'h0F0F_F0F0, 4'hF, 11'h7FC, 4'hF};
        vecs[3] = '{1'b0, 32'h0000_0800, 32'h8000_0001, 4'h0, 11'h000, 4'hF};
        vecs[4] = '{1'b1, 32'h0000_0002, 32'h0000_0000, 4'h8, 11'h000, 4'h8};
        vecs[5] = '{1'b0, 32'h1234_57FE, 32'hCAFE_F00D, 4'h0, 11'h7FC, 4'hF};

        RESETN = 0;
        idle_inputs();
        CTRL_AWADDR = 0; CTRL_ARADDR = 0; CTRL_WDATA = 0; CTRL_WSTRB = 0; REG_RDATA = 0;
        repeat (3) @(negedge CLOCK);
        #1 chk("rst_strobes", {REG_WR, REG_RD, REG_ADDR, REG_WDATA, REG_BE}, 49'h0);
        chk("rst_axi", {CTRL_AWREADY, CTRL_WREADY, CTRL_ARREADY, CTRL_BVALID,
                        CTRL_RVALID, CTRL_BRESP, CTRL_RRESP, CTRL_RDATA}, 41'h0);
        RESETN = 1;

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].is_wr) do_write(vecs[i]);
            else               do_read(vecs[i]);
        end

        // Simultaneous requests after reset: write first, then read first.
        apply_reset();
        @(negedge CLOCK);
        CTRL_AWVALID = 1; CTRL_WVALID = 1; CTRL_ARVALID = 1;
        CTRL_AWADDR = 32'h10; CTRL_ARADDR = 32'h20; REG_READY = 1; REG_RDATA_VALID = 1;
        REG_RDATA = 32'h5555_AAAA;
        #1 chk("arb1", {CTRL_AWREADY, CTRL_WREADY, CTRL_ARREADY}, 3'b110);
        @(negedge CLOCK);
        CTRL_AWVALID = 0; CTRL_WVALID = 0;
        #1 chk("arb1_wr", {REG_WR, CTRL_ARREADY}, 2'b10);
        @(negedge CLOCK);
        CTRL_BREADY = 1;
        @(negedge CLOCK);
        CTRL_BREADY = 0; CTRL_AWVALID = 1; CTRL_WVALID = 1;
        #1 chk("arb2", {CTRL_AWREADY, CTRL_WREADY, CTRL_ARREADY}, 3'b001);
        @(negedge CLOCK);
        CTRL_ARVALID = 0; CTRL_AWVALID = 0; CTRL_WVALID = 0;
        #1 chk("arb2_rd", {REG_RD, REG_ADDR}, {1'b1, 11'h020});
        @(negedge CLOCK);
        CTRL_RREADY = 1;
        @(negedge CLOCK);
        CTRL_RREADY = 0; REG_READY = 0; REG_RDATA_VALID = 0;

        // Stalled read: ready after 3 waits, data 4 cycles later, RREADY low for 5.
        @(negedge CLOCK);
        CTRL_ARVALID = 1; CTRL_ARADDR = 32'h104;
        @(negedge CLOCK);
        CTRL_ARVALID = 0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) REG_READY = 1;
            #1 if (REG_RD) n++;
            @(negedge CLOCK);
        end
        REG_READY = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin REG_RDATA_VALID = 1; REG_RDATA = 32'h9876_5432; end
            #1 if (REG_RD) n++;
            @(negedge CLOCK);
        end
        REG_RDATA_VALID = 0; REG_RDATA = 32'h0;
        chk("stall_rd_cycles", n, 4);
        stable = 1; beats = 0; held = CTRL_RDATA;
        for (int i = 0; i < 5; i++) begin
            #1 if (!CTRL_RVALID || CTRL_RDATA !== held) stable = 0;
            @(negedge CLOCK);
        end
        chk("stall_rdata", held, 32'h9876_5432);
        chk("stall_stable", stable, 1'b1);
        CTRL_RREADY = 1;
        #1 if (CTRL_RVALID) beats++;
        @(negedge CLOCK);
        CTRL_RREADY = 1;
        for (int i = 0; i < 4; i++) begin
            #1 if (CTRL_RVALID) beats++;
            @(negedge CLOCK);
        end
        CTRL_RREADY = 0;
        chk("stall_beats", beats, 1);

        // AW without W is not accepted.
        CTRL_AWVALID = 1; CTRL_AWADDR = 32'h40; CTRL_WDATA = 32'h77; CTRL_WSTRB = 4'h1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            #1 if (CTRL_AWREADY || CTRL_WREADY || REG_WR) n++;
            @(negedge CLOCK);
        end
        chk("aw_only", n, 0);
        CTRL_WVALID = 1; REG_READY = 1;
        #1 chk("aw_w_join", {CTRL_AWREADY, CTRL_WREADY}, 2'b11);
        @(negedge CLOCK);
        CTRL_AWVALID = 0; CTRL_WVALID = 0;
        #1 chk("aw_w_issue", {REG_WR, REG_ADDR, REG_BE}, {1'b1, 11'h040, 4'h1});
        @(negedge CLOCK);
        CTRL_BREADY = 1;
        @(negedge CLOCK);
        CTRL_BREADY = 0; REG_READY = 0;

`ifdef COREAXI4DMACONTROLLER_CTRL_IF_TIMEOUT_EN
        // Read with no data ever: aborts after 16 issue cycles with SLVERR.
        @(negedge CLOCK);
        CTRL_ARVALID = 1; CTRL_ARADDR = 32'h200;
        @(negedge CLOCK);
        CTRL_ARVALID = 0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            #1 if (CTRL_RVALID) break;
            if (REG_RD) n++;
            @(negedge CLOCK);
        end
        chk("to_rvalid", CTRL_RVALID, 1'b1);
        chk("to_cycles", n, 16);
        chk("to_resp", {CTRL_RRESP, CTRL_RDATA, REG_RD}, {2'b10, 32'h0, 1'b0});
        CTRL_RREADY = 1;
        @(negedge CLOCK);
        CTRL_RREADY = 0;
`endif

        // Reset in the middle of RD_ISSUE abandons the access.
        @(negedge CLOCK);
        CTRL_ARVALID = 1; CTRL_ARADDR = 32'h300;
        @(negedge CLOCK);
        CTRL_ARVALID = 0;
        #1 chk("mid_rd", REG_RD, 1'b1);
        RESETN = 0;
        #1 chk("mid_rst_drop", REG_RD, 1'b0);
        repeat (2) @(negedge CLOCK);
        RESETN = 1; CTRL_RREADY = 1; CTRL_BREADY = 1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            #1 if (CTRL_RVALID || CTRL_BVALID || REG_RD || REG_WR) n++;
            @(negedge CLOCK);
        end
        chk("mid_rst_quiet", n, 0);
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
